// File: rtl/tt_zhouzhouthezhou_segdec_if.sv
// Bundle of the pad-side signals of the seven-segment decoder.
//   ui_in   : segment pattern (bit0=a .. bit6=g, bit7=dp)
//   uio_in  : bit0 strobe, bit1 synchronous clear
//   uo_out  : [3:0] newest digit, [7:4] previous digit
//   uio_out : bit4 valid, bit5 error, bit6 overflow, bit7 busy
//   uio_oe  : output enables for uio_out
// master drives the pattern/control side, slave is the decoder.
interface tt_zhouzhouthezhou_segdec_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_zhouzhouthezhou_segdec.sv
// Seven-segment pattern decoder with a stability filter and a two-digit
// history register.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : ignored
//   ui_in   : segment pattern (bit0=a .. bit6=g, bit7=dp)
//   uio_in  : bit0 strobe, bit1 synchronous clear (priority over FSM)
//   uo_out  : [3:0] newest digit, [7:4] previous digit
//   uio_out : bit4 valid pulse, bit5 error sticky, bit6 overflow sticky,
//             bit7 busy, bits 3:0 zero
//   uio_oe  : constant 8'hF0
// A pattern is decoded once it has been sampled STABLE_CYCLES times in a
// row while strobe is high; strobe must then drop before the next capture.
module tt_zhouzhouthezhou_segdec #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE, HOLD} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  localparam logic [3:0] OVF_CODE = 4'hE;

  state_t     state;
  logic [7:0] cap;
  logic [3:0] cnt;
  logic [7:0] digits;
  logic       valid;
  logic       err;
  logic       ovf;

  logic       strobe;
  logic       clear;
  logic [3:0] code;
  logic       code_ok;
  logic       unused_inputs;

  assign strobe        = uio_in[0];
  assign clear         = uio_in[1];
  assign unused_inputs = ^{ena, uio_in[7:2]};

  // Decode of the captured pattern; only consulted in DECODE.
  always_comb begin
    code    = '0;
    code_ok = 1'b1;
    case (cap)
      8'h3F:   code = 4'd0;
      8'h06:   code = 4'd1;
      8'h5B:   code = 4'd2;
      8'h4F:   code = 4'd3;
      8'h66:   code = 4'd4;
      8'h6D:   code = 4'd5;
      8'h7D:   code = 4'd6;
      8'h07:   code = 4'd7;
      8'h7F:   code = 4'd8;
      8'h67:   code = 4'd9;
      8'h80:   code = OVF_CODE;
      default: code_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cap    <= '0;
      cnt    <= '0;
      digits <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        cap    <= '0;
        cnt    <= '0;
        digits <= '0;
        err    <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (strobe) begin
              cap   <= ui_in;
              cnt   <= 4'd1;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (!strobe) begin
              state <= IDLE;
            end else if (ui_in != cap) begin
              cap <= ui_in;
              cnt <= 4'd1;
            end else begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == STABLE) state <= DECODE;
            end
          end
          DECODE: begin
            if (code_ok) begin
              digits <= {digits[3:0], code};
              valid  <= 1'b1;
              if (code == OVF_CODE) ovf <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= HOLD;
          end
          HOLD: begin
            if (!strobe) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign uo_out  = digits;
  assign uio_out = {(state != IDLE), ovf, err, valid, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_zhouzhouthezhou_segdec.sv
module tb_tt_zhouzhouthezhou_segdec;

  localparam int S = 4;

  logic clk;
  logic rst_n;
  logic ena;

  tt_zhouzhouthezhou_segdec_if bus ();

  tt_zhouzhouthezhou_segdec #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  digits;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference state: digit history and stickies.
  logic [7:0] m_digits;
  logic       m_err;
  logic       m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Seven-segment table: index is the digit value.
  function automatic int ref_code(input logic [7:0] p);
    logic [7:0] segs [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67};
    for (int i = 0; i < 10; i++) if (p == segs[i]) return i;
    if (p == 8'h80) return 14;
    return -1;
  endfunction

  // Monitor: every cycle with valid high must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && bus.uio_out[4]) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(bus.uo_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_digits", 32'(bus.uo_out), 32'(e.digits));
        check("valid_ovf", 32'(bus.uio_out[6]), 32'(e.ovf));
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_digits"}, 32'(bus.uo_out), 32'(m_digits));
    check({tag, "_err"}, 32'(bus.uio_out[5]), 32'(m_err));
    check({tag, "_ovf"}, 32'(bus.uio_out[6]), 32'(m_ovf));
    check({tag, "_busy"}, 32'(bus.uio_out[7]), 32'd0);
    check({tag, "_low"}, 32'({bus.uio_oe, bus.uio_out[3:0]}), 32'hF00);
  endtask

  // Strobe held high for the whole sequence, then three low cycles.
  task automatic burst(input logic [7:0] seq[$], input bit check_busy, input string tag);
    int run = 0;
    int dec = -1;
    int unsigned base;
    logic [7:0] prev = '0;
    for (int j = 0; j < seq.size(); j++) begin
      run  = (j == 0 || seq[j] != prev) ? 1 : run + 1;
      prev = seq[j];
      if (run == S && dec < 0) dec = j;
    end
    @(negedge clk);
    base = cyc;
    if (dec >= 0) begin
      int c;
      c = ref_code(seq[dec]);
      if (c >= 0) begin
        m_digits = {m_digits[3:0], 4'(c)};
        if (c == 14) m_ovf = 1'b1;
        sb.push_back('{m_digits, m_ovf, base + 32'(dec) + 2});
      end else begin
        m_err = 1'b1;
      end
    end
    for (int j = 0; j < seq.size(); j++) begin
      bus.ui_in  = seq[j];
      bus.uio_in = 8'h01;
      @(negedge clk);
    end
    if (check_busy) check({tag, "_busy_hi"}, 32'(bus.uio_out[7]), 32'd1);
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'($urandom);
    repeat (3) @(negedge clk);
    check_idle_outputs(tag);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.uio_in = 8'h02;
    @(negedge clk);
    bus.uio_in = 8'h00;
    m_digits = '0;
    m_err    = 1'b0;
    m_ovf    = 1'b0;
    check_idle_outputs("clear");
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] segs [11] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                              8'h7D, 8'h07, 8'h7F, 8'h67, 8'h80};
    if ($urandom_range(0, 9) < 8) return segs[$urandom_range(0, 10)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] q[$];
    ena        = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    m_digits   = '0;
    m_err      = 1'b0;
    m_ovf      = 1'b0;
    rst_n      = 1'b0;
    #23;
    check("reset_uo", 32'(bus.uo_out), 32'h00);
    check("reset_uio", 32'(bus.uio_out), 32'h00);
    check("reset_oe", 32'(bus.uio_oe), 32'hF0);
    @(negedge clk);
    rst_n = 1'b1;

    q = '{8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B, 8'h5B};
    burst(q, 1'b1, "single");
    q = '{8'h4F, 8'h4F, 8'h4F, 8'h4F, 8'h4F};
    burst(q, 1'b0, "two_a");
    q = '{8'h67, 8'h67, 8'h67, 8'h67};
    burst(q, 1'b0, "two_b");
    check("two_digit_value", 32'(bus.uo_out), 32'h39);
    q = '{8'h06, 8'h06, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    burst(q, 1'b0, "glitch");
    check("glitch_low", 32'(bus.uo_out[3:0]), 32'd8);
    q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    burst(q, 1'b0, "invalid");
    q = '{8'h80, 8'h80, 8'h80, 8'h80};
    burst(q, 1'b0, "overflow");
    check("overflow_low", 32'(bus.uo_out[3:0]), 32'hE);
    do_clear();
    q = '{8'h6D, 8'h6D};
    burst(q, 1'b0, "abort");

    for (int b = 0; b < 40; b++) begin
      int n;
      logic [7:0] v;
      n = $urandom_range(1, 9);
      q = {};
      v = pick();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) v = pick();
        q.push_back(v);
      end
      burst(q, 1'b0, "rand");
      if (b == 20) do_clear();
    end

    // Reset asserted mid-filter: outputs must drop without a clock edge.
    @(negedge clk);
    bus.ui_in  = 8'h5B;
    bus.uio_in = 8'h01;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_digits = '0;
    m_err    = 1'b0;
    m_ovf    = 1'b0;
    check("async_rst_uo", 32'(bus.uo_out), 32'h00);
    check("async_rst_uio", 32'(bus.uio_out), 32'h00);
    bus.uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    q = '{8'h5B, 8'h5B, 8'h5B};
    burst(q, 1'b0, "post_rst_short");
    q = '{8'h5B, 8'h5B, 8'h5B, 8'h5B};
    burst(q, 1'b0, "post_rst_full");

    repeat (4) @(negedge clk);
    check("pending_valid", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_zhouzhouthezhou_segdec.md
TT_ZHOUZHOUTHEZHOU_SEGDEC -- requirements
Module: tt_zhouzhouthezhou_segdec

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical pattern samples required before decode; legal range is 2..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ui_in, input, 8 bits: segment pattern, bit0=a … bit6=g, bit7=dp.
REQ-005 SHALL have port uio_in, input, 8 bits: bit0=strobe, bit1=clear (synchronous, active-high); bits 7:2 unused.
REQ-006 SHALL have port uo_out, output, 8 bits: [3:0] newest digit, [7:4] previous digit.
REQ-007 SHALL have port uio_out, output, 8 bits: bit4=valid pulse, bit5=error sticky, bit6=overflow sticky, bit7=busy, bits 3:0 = 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.
REQ-009 SHALL have port ena, input, 1 bit: ignored.

Function
REQ-010 SHALL decode patterns as follows:
- Digits: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 67->9.
- 80 -> overflow code 4'hE.
- Every other value is invalid.
REQ-011 SHALL implement FSM states IDLE, SETTLE, DECODE and HOLD; busy (uio_out[7]) is 1 in every state except IDLE.
REQ-012 IDLE: on an edge sampling strobe=1, SHALL capture ui_in into cap, set cnt=1 and go to SETTLE.
REQ-013 SETTLE, strobe=0: SHALL return to IDLE with no digit or flag change (abort).
REQ-014 SETTLE, strobe=1 and ui_in!=cap: SHALL load cap<=ui_in and cnt<=1 (restart filter).
REQ-015 SETTLE, strobe=1 and ui_in==cap: SHALL increment cnt; on the edge where the incremented cnt equals STABLE_CYCLES, SHALL go to DECODE.
REQ-016 DECODE, valid digit or overflow pattern: SHALL perform one action at the next edge:
- shift: uo_out[7:4]<=uo_out[3:0], uo_out[3:0]<=code;
- valid<=1;
- overflow sticky is set when the code is E.
REQ-017 DECODE, invalid pattern: SHALL leave the digits unchanged, keep valid=0 and set error sticky.
REQ-018 DECODE SHALL exit to HOLD unconditionally, regardless of strobe.
REQ-019 valid SHALL be high exactly one cycle per DECODE with a valid or overflow pattern; it is a registered output.
REQ-020 HOLD: SHALL remain while strobe=1 and go to IDLE on an edge sampling strobe=0; a new capture requires strobe to deassert first.
REQ-021 Latency: with strobe first sampled high at edge E0 and ui_in constant, valid SHALL be high in the cycle after edge E(STABLE_CYCLES).
REQ-022 clear=1 on an edge SHALL zero both digits and both stickies, force valid=0 and move the FSM to IDLE; clear takes priority over every FSM action.
REQ-023 Stickies SHALL hold until clear or reset; a simultaneous set and clear resolves to clear.

Reset
REQ-024 rst_n=0 SHALL immediately force:
- uo_out=8'h00;
- valid, error and overflow = 0;
- FSM=IDLE, cap=0, cnt=0.
REQ-025 Reset asserted mid-SETTLE or mid-DECODE SHALL discard the capture; after release, the first strobe-high edge restarts from IDLE.
REQ-026 uio_oe SHALL be 8'hF0 and uio_out[3:0] SHALL be 0 at all times, including during reset.

Verification
REQ-027 Single digit: reset, ui_in=5B, strobe high for 8 cycles. Required: valid for exactly 1 cycle after E4; uo_out=8'h02; busy=1 until strobe is low.
REQ-028 Two digits: decode 4F then 67 (strobe dropped between them). Required: uo_out=8'h39 and two valid pulses.
REQ-029 Glitch: with strobe high, ui_in=06,06,7F,7F,7F,7F. Required: the filter restarts at 7F; valid after the 4th consecutive 7F; uo_out[3:0]=8.
REQ-030 Invalid/overflow: decode 01. Required: error=1, no valid, digits unchanged. Then decode 80. Required: uo_out[3:0]=E, overflow=1; clear zeroes uo_out and both stickies.
REQ-031 Abort: strobe high for 2 cycles, then low. Required: no valid, uo_out unchanged, busy back to 0.
REQ-032 Reset mid-SETTLE: rst_n low for 1 cycle during SETTLE. Required: outputs go to zero asynchronously; no valid until a fresh strobe plus 4 stable samples.
